// File: rtl/layer_tap_capture.sv
// Single-shot capture of one tapped activation stream into a buffer, followed by a valid/ready readout.
// Optional TAP_FRAME_ALIGN_EN: capture only begins on the first sample of a frame of the selected tap.
module layer_tap_capture #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_TAPS   = 5,
  parameter int DEPTH      = 1024,
  parameter int FRAME_LEN  = 1024,
  localparam int SEL_W     = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1,
  localparam int AW        = $clog2(DEPTH),
  localparam int LEN_W     = AW + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_TAPS-1:0]            tap_valid,
  input  logic [NUM_TAPS*DATA_WIDTH-1:0] tap_data,
  input  logic [SEL_W-1:0]               tap_sel,
  input  logic [LEN_W-1:0]               capture_len,
  input  logic                           arm,
  input  logic                           rd_ready,
  output logic                           rd_valid,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           busy,
  output logic [15:0]                    miss_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    CAPTURE,
    PREFETCH,
    READOUT
  } state_t;

  state_t                  state_q;
  logic [SEL_W-1:0]        sel_q;
  logic [LEN_W-1:0]        len_q;
  logic [AW-1:0]           wrIdx_q;
  logic [AW-1:0]           rdIdx_q;
  logic                    rdValid_q;
  logic [DATA_WIDTH-1:0]   rdData_q;
  logic [15:0]             missCnt_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    selValid;
  logic [DATA_WIDTH-1:0]   selData;
  logic                    qualify;
  logic [SEL_W-1:0]        sel_d;
  logic [LEN_W-1:0]        len_d;
  logic [AW-1:0]           rdIdx_d;
  logic                    lastWrite;
  logic                    lastRead;
  logic                    wrEn;
  logic [AW-1:0]           wrAddr;

  assign selValid  = tap_valid[sel_q];
  assign selData   = tap_data[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
  assign rdIdx_d   = rdIdx_q + 1'b1;
  assign lastWrite = ({1'b0, wrIdx_q} == (len_q - 1'b1));
  assign lastRead  = ({1'b0, rdIdx_q} == (len_q - 1'b1));

  // Out-of-range tap indices fall back to tap 0; zero or oversize lengths mean a full buffer.
  always_comb begin
    sel_d = tap_sel;
    len_d = capture_len;
    if (int'(tap_sel) >= NUM_TAPS) sel_d = '0;
    if (capture_len == '0 || capture_len > LEN_W'(DEPTH)) len_d = LEN_W'(DEPTH);
  end

`ifdef TAP_FRAME_ALIGN_EN
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [FW-1:0] frameCnt_q [NUM_TAPS];

  // Free-running per-tap position within the current frame.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (!rst_n) begin
        frameCnt_q[i] <= '0;
      end else if (tap_valid[i]) begin
        frameCnt_q[i] <= (frameCnt_q[i] == FW'(FRAME_LEN - 1)) ? '0 : frameCnt_q[i] + 1'b1;
      end
    end
  end

  assign qualify = selValid && (frameCnt_q[sel_q] == '0);
`else
  assign qualify = selValid;
`endif

  always_comb begin
    wrEn   = 1'b0;
    wrAddr = wrIdx_q;
    if (state_q == ARMED && qualify) begin
      wrEn   = 1'b1;
      wrAddr = '0;
    end else if (state_q == CAPTURE && selValid) begin
      wrEn = 1'b1;
    end
  end

  // Buffer carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= selData;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      len_q     <= '0;
      wrIdx_q   <= '0;
      rdIdx_q   <= '0;
      rdValid_q <= 1'b0;
      rdData_q  <= '0;
      missCnt_q <= '0;
    end else begin
      if ((state_q == PREFETCH || state_q == READOUT) && selValid && missCnt_q != 16'hFFFF)
        missCnt_q <= missCnt_q + 16'd1;

      case (state_q)
        IDLE: begin
          if (arm) begin
            sel_q     <= sel_d;
            len_q     <= len_d;
            wrIdx_q   <= '0;
            missCnt_q <= '0;
            state_q   <= ARMED;
          end
        end
        ARMED: begin
          if (qualify) begin
            wrIdx_q <= AW'(1);
            state_q <= (len_q == LEN_W'(1)) ? PREFETCH : CAPTURE;
          end
        end
        CAPTURE: begin
          if (selValid) begin
            wrIdx_q <= wrIdx_q + 1'b1;
            if (lastWrite) state_q <= PREFETCH;
          end
        end
        PREFETCH: begin
          rdData_q  <= mem[0];
          rdValid_q <= 1'b1;
          rdIdx_q   <= '0;
          state_q   <= READOUT;
        end
        READOUT: begin
          // Read the following word during the handshake so the sink sees no bubble.
          if (rdValid_q && rd_ready) begin
            if (lastRead) begin
              rdValid_q <= 1'b0;
              state_q   <= IDLE;
            end else begin
              rdIdx_q  <= rdIdx_d;
              rdData_q <= mem[rdIdx_d];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_valid = rdValid_q;
  assign rd_data  = rdData_q;
  assign busy     = (state_q != IDLE);
  assign miss_cnt = missCnt_q;

endmodule

// File: doc/layer_tap_capture.md
LAYER_TAP_CAPTURE -- requirements
Module: layer_tap_capture

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width in bits (signed two's complement).
REQ-002 SHALL have parameter NUM_TAPS, default 5, number of tapped activation streams (enc1..enc3, dec1, dec2).
REQ-003 SHALL have parameter DEPTH, default 1024, capture buffer words; power of two, at least 2.
REQ-004 SHALL have parameter FRAME_LEN, default 1024, samples per frame per tap (32x32).
REQ-005 SHALL have port clk, input, 1, the single clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-007 SHALL have port tap_valid, input, NUM_TAPS, per-tap sample strobe.
REQ-008 SHALL have port tap_data, input, NUM_TAPS*DATA_WIDTH, packed tap samples; tap i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port tap_sel, input, clog2(NUM_TAPS), tap index, sampled only when arm is accepted.
REQ-010 SHALL have port capture_len, input, clog2(DEPTH)+1, words to capture, sampled only when arm is accepted.
REQ-011 SHALL have port arm, input, 1, single-cycle capture request.
REQ-012 SHALL have port rd_ready, input, 1, readout sink ready.
REQ-013 SHALL have port rd_valid, output, 1, readout word valid.
REQ-014 SHALL have port rd_data, output, DATA_WIDTH, readout word.
REQ-015 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-016 SHALL have port miss_cnt, output, 16, saturating count of selected-tap samples arriving during PREFETCH/READOUT.

Function
REQ-017 SHALL implement FSM with states IDLE, ARMED, CAPTURE, PREFETCH and READOUT.
REQ-018 In IDLE with arm=1: latch tap_sel and the effective length, go to ARMED, clear miss_cnt; arm in any other state SHALL be ignored.
REQ-019 Effective length SHALL be DEPTH when capture_len=0 or capture_len>DEPTH, otherwise capture_len.
REQ-020 tap_sel >= NUM_TAPS SHALL be latched as tap 0.
REQ-021 In ARMED: the first qualifying sample of the latched tap SHALL be written to word 0 in that same cycle, with transition to CAPTURE, or to PREFETCH when length=1.
REQ-022 In CAPTURE: each selected-tap valid SHALL write the next word; when the word written equals length-1, go to PREFETCH; no gaps and no duplicates; non-selected taps SHALL be ignored.
REQ-023 PREFETCH SHALL last exactly one cycle, issue a synchronous buffer read of word 0, then go to READOUT.
REQ-024 In READOUT: rd_valid=1 with rd_data = current word; rd_data SHALL be held stable while rd_valid=1 and rd_ready=0.
REQ-025 On each rd_valid and rd_ready handshake the word index SHALL advance, and the next word SHALL be presented on the next cycle with no bubble.
REQ-026 The handshake on word length-1 SHALL return the FSM to IDLE, with rd_valid=0 on the next cycle.
REQ-027 Selected-tap valid during PREFETCH or READOUT SHALL increment miss_cnt, saturating at 16'hFFFF; the sample itself is not stored.
REQ-028 Captured samples SHALL be stored and returned bit-exact, with no sign or width change.

Reset
REQ-029 With rst_n=0 at a clock edge: FSM to IDLE; rd_valid=0, rd_data=0, busy=0, miss_cnt=0; all word indices and frame counters cleared; buffer contents are undefined.
REQ-030 Reset asserted mid-capture or mid-readout SHALL abort the operation, and the next rd_valid SHALL only follow a fresh arm.

Configuration
REQ-031 Macro TAP_FRAME_ALIGN_EN, when defined, SHALL add one free-running counter per tap, counting that tap's valids modulo FRAME_LEN from reset.
REQ-032 With TAP_FRAME_ALIGN_EN defined, a sample qualifies in ARMED only when its tap counter equals 0, i.e. the sample is the first of a frame.
REQ-033 Without TAP_FRAME_ALIGN_EN, the frame counters SHALL be absent, and any selected-tap valid in ARMED qualifies.

Verification
REQ-034 Arm with tap_sel=2 and capture_len=4, then drive tap 2 with values -3, 7, 100, -32768 (other taps toggling) and rd_ready=1 -> rd_data -3, 7, 100, -32768 on consecutive cycles; busy falls after the 4th handshake.
REQ-035 Readout of 3 words with rd_ready pattern 1,0,0,1,1 -> every word held through the stalls, and exactly 3 handshakes occur.
REQ-036 capture_len=0 with DEPTH=1024 -> exactly 1024 words captured and returned in order; capture_len=2000 behaves identically.
REQ-037 Five selected-tap valids during READOUT -> miss_cnt=5; the next arm clears it to 0.
REQ-038 rst_n pulsed low after 10 captured words -> next cycle busy=0 and rd_valid=0; a second arm then captures correctly from word 0.
REQ-039 With TAP_FRAME_ALIGN_EN and FRAME_LEN=8, arm after 3 tap-0 samples -> capture starts on the 9th tap-0 sample since reset.
